// File: rtl/inst_sram_responder_pkg.sv
// Shared constants, types and helpers for the instruction SRAM responder.
// Bus widths, the reset fetch address and the lane-merge function live here.
package inst_sram_responder_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [ADDR_W-1:0] RESET_PC_NEXT    = 32'h1c00_0000;
  localparam logic [DATA_W-1:0] OOR_DATA_DEFAULT = 32'h0000_0000;

  // Which source currently drives the registered read data.
  typedef enum logic [1:0] {
    SrcZero,
    SrcArray,
    SrcOor
  } rdata_src_e;

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] merged;
    merged = old_word;
    for (int l = 0; l < int'(BE_W); l++) begin
      if (be[l]) merged[8*l +: 8] = new_word[8*l +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/inst_sram_responder_if.sv
// Fetch-stage instruction SRAM port: request from the master, read data from the slave.
interface inst_sram_responder_if;
  import inst_sram_responder_pkg::*;

  logic              sram_en;
  logic [BE_W-1:0]   sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  modport master (
    output sram_en,
    output sram_we,
    output sram_addr,
    output sram_wdata,
    input  sram_rdata
  );

  modport slave (
    input  sram_en,
    input  sram_we,
    input  sram_addr,
    input  sram_wdata,
    output sram_rdata
  );

endinterface

// File: rtl/inst_sram_responder_sram_byte_array.sv
// Word storage with per-lane write enables and a synchronous write-first read port.
// The registered read word holds whenever the port is not enabled.
module inst_sram_responder_sram_byte_array
  import inst_sram_responder_pkg::*;
#(
  parameter int unsigned WORD_AW   = 14,
  parameter string       INIT_FILE = ""
) (
  input  logic               i_clk,
  input  logic               i_en,
  input  logic [BE_W-1:0]    i_we,
  input  logic [WORD_AW-1:0] i_idx,
  input  logic [DATA_W-1:0]  i_wdata,
  output logic [DATA_W-1:0]  o_rdata
);

  localparam int unsigned Depth = 2 ** WORD_AW;

  logic [DATA_W-1:0] r_mem [0:Depth-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int l = 0; l < int'(BE_W); l++) begin
        if (i_we[l]) r_mem[i_idx][8*l +: 8] <= i_wdata[8*l +: 8];
      end
      r_rdata <= merge_lanes(r_mem[i_idx], i_wdata, i_we);
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_sram_responder.sv
// Instruction SRAM responder: address decode, out-of-range substitution, read-data hold,
// sticky error flags and access counters around the byte-writable word array.
module inst_sram_responder
  import inst_sram_responder_pkg::*;
#(
  parameter int unsigned       WORD_AW   = 14,
  parameter logic [ADDR_W-1:0] BASE_ADDR = RESET_PC_NEXT,
  parameter logic [DATA_W-1:0] OOR_DATA  = OOR_DATA_DEFAULT,
  parameter string             INIT_FILE = ""
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  inst_sram_responder_if.slave        bus,
  output logic                        o_err_oor,
  output logic                        o_err_misalign,
  output logic [31:0]                 o_rd_count,
  output logic [31:0]                 o_wr_count
);

  logic [ADDR_W-1:0]  w_off;
  logic               w_in_range;
  logic [WORD_AW-1:0] w_idx;
  logic               w_arr_en;
  logic [BE_W-1:0]    w_arr_we;
  logic               w_is_read;
  logic [DATA_W-1:0]  w_arr_rdata;
  logic [DATA_W-1:0]  w_rdata;

  rdata_src_e         r_src;
  logic               r_err_oor;
  logic               r_err_misalign;
  logic [31:0]        r_rd_count;
  logic [31:0]        r_wr_count;

  always_comb begin
    w_off      = bus.sram_addr - BASE_ADDR;
    w_in_range = (w_off >> (WORD_AW + 2)) == '0;
    w_idx      = w_off[WORD_AW+1:2];
    w_arr_en   = bus.sram_en & w_in_range;
    // Reads still flow during reset so the first fetch is served; writes do not.
    w_arr_we   = i_reset ? '0 : bus.sram_we;
    w_is_read  = (bus.sram_we == '0);
  end

  inst_sram_responder_sram_byte_array #(
    .WORD_AW   (WORD_AW),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .i_clk   (i_clk),
    .i_en    (w_arr_en),
    .i_we    (w_arr_we),
    .i_idx   (w_idx),
    .i_wdata (bus.sram_wdata),
    .o_rdata (w_arr_rdata)
  );

  // The array register holds on idle cycles, so r_src alone preserves the last response.
  always_ff @(posedge i_clk) begin
    if (bus.sram_en) begin
      r_src <= w_in_range ? SrcArray : SrcOor;
    end else if (i_reset) begin
      r_src <= SrcZero;
    end

    if (i_reset) begin
      r_err_oor      <= 1'b0;
      r_err_misalign <= 1'b0;
      r_rd_count     <= '0;
      r_wr_count     <= '0;
    end else if (bus.sram_en) begin
      if (!w_in_range)                 r_err_oor      <= 1'b1;
      if (bus.sram_addr[1:0] != 2'b00) r_err_misalign <= 1'b1;
      if (w_is_read) r_rd_count <= r_rd_count + 32'd1;
      else           r_wr_count <= r_wr_count + 32'd1;
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (r_src)
      SrcArray: w_rdata = w_arr_rdata;
      SrcOor:   w_rdata = OOR_DATA;
      default:  w_rdata = '0;
    endcase
  end

  assign bus.sram_rdata  = w_rdata;
  assign o_err_oor       = r_err_oor;
  assign o_err_misalign  = r_err_misalign;
  assign o_rd_count      = r_rd_count;
  assign o_wr_count      = r_wr_count;

endmodule

// File: tb/tb_inst_sram_responder.sv
// Directed bench: requests push their expected response into a queue that a separate
// monitor drains one cycle later; counters and flags are checked inline.
module tb_inst_sram_responder;

  logic        clk;
  logic        rst;
  logic        err_oor;
  logic        err_misalign;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  int unsigned n_checks;
  int unsigned n_pass;
  logic [31:0] exp_q [$];

  inst_sram_responder_if bus ();

  inst_sram_responder #(
    .WORD_AW   (14),
    .BASE_ADDR (32'h1c00_0000),
    .OOR_DATA  (32'h0000_0000),
    .INIT_FILE ("")
  ) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .bus            (bus),
    .o_err_oor      (err_oor),
    .o_err_misalign (err_misalign),
    .o_rd_count     (rd_count),
    .o_wr_count     (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Drive one request for one cycle; inputs change on the falling edge.
  task automatic issue(input logic [3:0] we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
    bus.sram_en    = 1'b1;
    bus.sram_we    = we;
    bus.sram_addr  = addr;
    bus.sram_wdata = wdata;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.sram_en    = 1'b0;
    bus.sram_we    = 4'h0;
  endtask

  task automatic idle(input int n);
    bus.sram_en = 1'b0;
    bus.sram_we = 4'h0;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: a request seen at a rising edge yields rdata by the next falling edge.
  initial begin
    logic        pend;
    logic [31:0] exp;
    forever begin
      @(posedge clk);
      pend = bus.sram_en;
      @(negedge clk);
      if (pend) begin
        if (exp_q.size() == 0) begin
          check("rdata_unexpected", bus.sram_rdata, 32'hxxxx_xxxx);
        end else begin
          exp = exp_q.pop_front();
          check("rdata", bus.sram_rdata, exp);
        end
      end
    end
  end

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    rst            = 1'b1;
    bus.sram_en    = 1'b0;
    bus.sram_we    = 4'h0;
    bus.sram_addr  = 32'h0;
    bus.sram_wdata = 32'h0;
    repeat (3) @(negedge clk);

    check("reset_rdata", bus.sram_rdata, 32'h0);
    check("reset_err_oor", {31'h0, err_oor}, 32'h0);
    check("reset_err_misalign", {31'h0, err_misalign}, 32'h0);
    check("reset_rd_count", rd_count, 32'h0);
    check("reset_wr_count", wr_count, 32'h0);

    // Preload the first three words.
    rst = 1'b0;
    issue(4'hF, 32'h1c00_0000, 32'h0280_0c0c, 32'h0280_0c0c);
    issue(4'hF, 32'h1c00_0004, 32'h1122_3344, 32'h1122_3344);
    issue(4'hF, 32'h1c00_0008, 32'haabb_ccdd, 32'haabb_ccdd);
    idle(1);

    // 1: first fetch while reset is held.
    rst = 1'b1;
    issue(4'h0, 32'h1c00_0000, 32'h0, 32'h0280_0c0c);
    check("t1_rd_count", rd_count, 32'h0);
    check("t1_wr_count", wr_count, 32'h0);
    rst = 1'b0;

    // 2: rdata held across idle cycles.
    issue(4'h0, 32'h1c00_0004, 32'h0, 32'h1122_3344);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold", bus.sram_rdata, 32'h1122_3344);
    end
    check("t2_rd_count", rd_count, 32'd1);

    // 3: byte-lane write, write-first response, then readback.
    issue(4'b0101, 32'h1c00_0008, 32'h1122_3344, 32'haa22_cc44);
    issue(4'h0, 32'h1c00_0008, 32'h0, 32'haa22_cc44);
    check("t3_wr_count", wr_count, 32'd1);

    // 4: out-of-range read and write.
    check("t4_err_oor_before", {31'h0, err_oor}, 32'h0);
    issue(4'h0, 32'h1bff_fffc, 32'h0, 32'h0);
    check("t4_err_oor_set", {31'h0, err_oor}, 32'h1);
    issue(4'hF, 32'h1c01_0000, 32'hffff_ffff, 32'h0);
    issue(4'h0, 32'h1c00_0000, 32'h0, 32'h0280_0c0c);
    issue(4'h0, 32'h1c00_0004, 32'h0, 32'h1122_3344);
    issue(4'h0, 32'h1c00_0008, 32'h0, 32'haa22_cc44);
    idle(2);
    check("t4_err_oor_sticky", {31'h0, err_oor}, 32'h1);
    check("t4_rd_count", rd_count, 32'd6);
    check("t4_wr_count", wr_count, 32'd2);
    check("t4_err_misalign", {31'h0, err_misalign}, 32'h0);

    // 5: write during reset is dropped but the read side still answers.
    rst = 1'b1;
    issue(4'hF, 32'h1c00_0000, 32'hdead_beef, 32'h0280_0c0c);
    check("t5_wr_count", wr_count, 32'h0);
    check("t5_rd_count", rd_count, 32'h0);
    check("t5_err_oor_cleared", {31'h0, err_oor}, 32'h0);
    rst = 1'b0;
    issue(4'h0, 32'h1c00_0000, 32'h0, 32'h0280_0c0c);

    // 6: misaligned read indexes the word; counter wraps.
    issue(4'h0, 32'h1c00_0006, 32'h0, 32'h1122_3344);
    check("t6_err_misalign", {31'h0, err_misalign}, 32'h1);
    check("t6_rd_count", rd_count, 32'd2);
    force dut.r_rd_count = 32'hffff_ffff;
    #2;
    release dut.r_rd_count;
    @(negedge clk);
    check("t6_rd_count_forced", rd_count, 32'hffff_ffff);
    issue(4'h0, 32'h1c00_0000, 32'h0, 32'h0280_0c0c);
    check("t6_rd_count_wrap", rd_count, 32'h0);

    idle(3);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
